// File: rtl/axi4_switch_nx1_if.sv
// Signal bundle between axi4_switch_nx1 and its environment: NUM_S slave streams in, one master stream out.
// Optional axi_m0_tid_o exists only when AXI4_SWITCH_SRC_ID_EN is defined.
interface axi4_switch_nx1_if #(
  parameter int NUM_S   = 4,
  parameter int TDATA_L = 512,
  parameter int TUSER_L = 81,
  parameter int TKEEP_L = 16,
  parameter int SEL_W   = $clog2(NUM_S)
);
  logic [NUM_S-1:0]         s_req_supress;
  logic [NUM_S*TDATA_L-1:0] axi_s_tdata_i;
  logic [NUM_S*TUSER_L-1:0] axi_s_tuser_i;
  logic [NUM_S*TKEEP_L-1:0] axi_s_tkeep_i;
  logic [NUM_S-1:0]         axi_s_tlast_i;
  logic [NUM_S-1:0]         axi_s_tvalid_i;
  logic [NUM_S-1:0]         axi_s_tready_o;
  logic [TDATA_L-1:0]       axi_m0_tdata_o;
  logic [TUSER_L-1:0]       axi_m0_tuser_o;
  logic [TKEEP_L-1:0]       axi_m0_tkeep_o;
  logic                     axi_m0_tlast_o;
  logic                     axi_m0_tvalid_o;
  logic                     axi_m0_tready_i;
`ifdef AXI4_SWITCH_SRC_ID_EN
  logic [SEL_W-1:0]         axi_m0_tid_o;
`endif

  // slave: the switch itself; master: the environment feeding and draining it.
  modport slave (
    input  s_req_supress, axi_s_tdata_i, axi_s_tuser_i, axi_s_tkeep_i,
    input  axi_s_tlast_i, axi_s_tvalid_i, axi_m0_tready_i,
    output axi_s_tready_o, axi_m0_tdata_o, axi_m0_tuser_o, axi_m0_tkeep_o,
    output axi_m0_tlast_o, axi_m0_tvalid_o
`ifdef AXI4_SWITCH_SRC_ID_EN
    , output axi_m0_tid_o
`endif
  );

  modport master (
    output s_req_supress, axi_s_tdata_i, axi_s_tuser_i, axi_s_tkeep_i,
    output axi_s_tlast_i, axi_s_tvalid_i, axi_m0_tready_i,
    input  axi_s_tready_o, axi_m0_tdata_o, axi_m0_tuser_o, axi_m0_tkeep_o,
    input  axi_m0_tlast_o, axi_m0_tvalid_o
`ifdef AXI4_SWITCH_SRC_ID_EN
    , input axi_m0_tid_o
`endif
  );
endinterface

// File: rtl/axi4_switch_nx1.sv
// N-to-1 AXI4-Stream packet switch: packet-atomic round-robin with per-port suppress, registered output.
// Define AXI4_SWITCH_SRC_ID_EN to add axi_m0_tid_o carrying the source port index.
module axi4_switch_nx1 #(
  parameter int NUM_S   = 4,
  parameter int TDATA_L = 512,
  parameter int TUSER_L = 81,
  parameter int TKEEP_L = 16,
  parameter int SEL_W   = $clog2(NUM_S)
) (
  input logic              clk,
  input logic              rst,
  axi4_switch_nx1_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t             r_state, w_state_nxt;
  logic [SEL_W-1:0]   r_rr_ptr, r_lock_idx;
  logic [SEL_W-1:0]   w_rr_winner, w_grant_idx;
  logic               w_rr_found, w_grant_vld;
  logic [NUM_S-1:0]   w_eligible, w_tready, w_handshake;
  logic               w_out_ok, w_accept, w_accept_last;

  logic [TDATA_L-1:0] r_m0_tdata;
  logic [TUSER_L-1:0] r_m0_tuser;
  logic [TKEEP_L-1:0] r_m0_tkeep;
  logic               r_m0_tlast, r_m0_tvalid;

  assign w_out_ok      = ~r_m0_tvalid | bus.axi_m0_tready_i;
  assign w_eligible    = bus.axi_s_tvalid_i & ~bus.s_req_supress;
  assign w_handshake   = w_tready & bus.axi_s_tvalid_i;
  assign w_accept      = |w_handshake;
  assign w_accept_last = bus.axi_s_tlast_i[w_grant_idx];

  // Scan farthest-first so the nearest eligible port after r_rr_ptr is the last one written.
  always_comb begin
    logic [SEL_W-1:0] v_idx;
    // NOTE: every variable written in always_comb gets a default first; a path that skips it would infer a latch.
    v_idx       = '0;
    w_rr_winner = '0;
    w_rr_found  = 1'b0;
    for (int k = NUM_S; k >= 1; k--) begin
      v_idx = SEL_W'((int'(r_rr_ptr) + k) % NUM_S);
      if (w_eligible[v_idx]) begin
        w_rr_winner = v_idx;
        w_rr_found  = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept && !w_accept_last) w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_accept &&  w_accept_last) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // While locked the owner keeps the grant even with tvalid low; suppress only gates new packets.
  always_comb begin
    w_grant_idx = r_lock_idx;
    w_grant_vld = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_grant_idx = w_rr_winner;
        w_grant_vld = w_rr_found;
      end
      ST_LOCKED: begin
        w_grant_idx = r_lock_idx;
        w_grant_vld = 1'b1;
      end
      default: ;
    endcase
    w_tready = '0;
    if (w_grant_vld && w_out_ok && !rst) w_tready[w_grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr   <= SEL_W'(NUM_S - 1);
      r_lock_idx <= '0;
    end else if (w_accept) begin
      if (w_accept_last)            r_rr_ptr   <= w_grant_idx;
      else if (r_state == ST_IDLE)  r_lock_idx <= w_grant_idx;
    end
  end

  // NOTE: the wide datapath registers are reset too, so the master bus reads all-zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m0_tdata  <= '0;
      r_m0_tuser  <= '0;
      r_m0_tkeep  <= '0;
      r_m0_tlast  <= 1'b0;
      r_m0_tvalid <= 1'b0;
    end else if (w_accept) begin
      r_m0_tdata  <= bus.axi_s_tdata_i[int'(w_grant_idx)*TDATA_L +: TDATA_L];
      r_m0_tuser  <= bus.axi_s_tuser_i[int'(w_grant_idx)*TUSER_L +: TUSER_L];
      r_m0_tkeep  <= bus.axi_s_tkeep_i[int'(w_grant_idx)*TKEEP_L +: TKEEP_L];
      r_m0_tlast  <= w_accept_last;
      r_m0_tvalid <= 1'b1;
    end else if (bus.axi_m0_tready_i) begin
      r_m0_tvalid <= 1'b0;
    end
  end

`ifdef AXI4_SWITCH_SRC_ID_EN
  logic [SEL_W-1:0] r_m0_tid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_m0_tid <= '0;
    else if (w_accept) r_m0_tid <= w_grant_idx;
  end

  assign bus.axi_m0_tid_o = r_m0_tid;
`endif

  assign bus.axi_s_tready_o  = w_tready;
  assign bus.axi_m0_tdata_o  = r_m0_tdata;
  assign bus.axi_m0_tuser_o  = r_m0_tuser;
  assign bus.axi_m0_tkeep_o  = r_m0_tkeep;
  assign bus.axi_m0_tlast_o  = r_m0_tlast;
  assign bus.axi_m0_tvalid_o = r_m0_tvalid;

endmodule

// File: tb/tb_axi4_switch_nx1.sv
// Directed bench for axi4_switch_nx1 (NUM_S=4): arbitration order, locking, suppress, backpressure, reset.
// Source-ID beats are compared as well when AXI4_SWITCH_SRC_ID_EN is defined.
module tb_axi4_switch_nx1;
  localparam int NUM_S   = 4;
  localparam int TDATA_L = 512;
  localparam int TUSER_L = 81;
  localparam int TKEEP_L = 16;
  localparam int SEL_W   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi4_switch_nx1_if #(.NUM_S(NUM_S), .TDATA_L(TDATA_L), .TUSER_L(TUSER_L),
                       .TKEEP_L(TKEEP_L), .SEL_W(SEL_W)) bus ();

  axi4_switch_nx1 #(.NUM_S(NUM_S), .TDATA_L(TDATA_L), .TUSER_L(TUSER_L),
                    .TKEEP_L(TKEEP_L), .SEL_W(SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Per-port stimulus sources: beat index, total beats, packet length.
  int src_idx [NUM_S];
  int src_len [NUM_S];
  int src_pkt [NUM_S];

  // Master beats: {tid[3:0], 3'b0, tlast, tdata[31:0]}
  logic [39:0]      obs_q[$];
  logic [39:0]      exp_q[$];
  logic [NUM_S-1:0] seen_tready;

  task automatic check(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] beat_data(input int p, input int i);
    return 32'hD000_0000 | (p << 16) | i;
  endfunction

  function automatic logic [39:0] exp_beat(input int p, input int i, input logic last);
    logic [3:0] tid;
    tid = 4'd0;
`ifdef AXI4_SWITCH_SRC_ID_EN
    tid = 4'(p);
`endif
    return {tid, 3'b000, last, beat_data(p, i)};
  endfunction

  function automatic logic [39:0] cur_beat();
    logic [3:0] tid;
    tid = 4'd0;
`ifdef AXI4_SWITCH_SRC_ID_EN
    tid = 4'(bus.axi_m0_tid_o);
`endif
    return {tid, 3'b000, bus.axi_m0_tlast_o, bus.axi_m0_tdata_o[31:0]};
  endfunction

  task automatic drive_port(input int p);
    bus.axi_s_tvalid_i[p] = (src_idx[p] < src_len[p]);
    bus.axi_s_tlast_i[p]  = (((src_idx[p] + 1) % src_pkt[p]) == 0);
    bus.axi_s_tdata_i[p*TDATA_L +: TDATA_L] = TDATA_L'(beat_data(p, src_idx[p]));
    bus.axi_s_tuser_i[p*TUSER_L +: TUSER_L] = TUSER_L'(beat_data(p, src_idx[p]) ^ 32'hFFFF_FFFF);
    bus.axi_s_tkeep_i[p*TKEEP_L +: TKEEP_L] = TKEEP_L'(src_idx[p] + 1);
  endtask

  task automatic load(input int p, input int len, input int pkt);
    src_idx[p] = 0;
    src_len[p] = len;
    src_pkt[p] = pkt;
    drive_port(p);
  endtask

  // One clock: sample at negedge, then advance sources that handshook on the posedge.
  task automatic cycle(input logic tr);
    logic [NUM_S-1:0] hs;
    bus.axi_m0_tready_i = tr;
    @(negedge clk);
    seen_tready = bus.axi_s_tready_o;
    hs = bus.axi_s_tready_o & bus.axi_s_tvalid_i;
    if (bus.axi_m0_tvalid_o && bus.axi_m0_tready_i) obs_q.push_back(cur_beat());
    @(posedge clk);
    #1;
    for (int p = 0; p < NUM_S; p++) begin
      if (hs[p]) begin
        src_idx[p]++;
        drive_port(p);
      end
    end
  endtask

  task automatic compare_obs(input string tag);
    check({tag, "_count"}, 512'(obs_q.size()), 512'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), 512'(obs_q[i]), 512'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst                 = 1'b1;
    bus.s_req_supress   = '0;
    bus.axi_s_tdata_i   = '0;
    bus.axi_s_tuser_i   = '0;
    bus.axi_s_tkeep_i   = '0;
    bus.axi_s_tlast_i   = '0;
    bus.axi_s_tvalid_i  = '1;
    bus.axi_m0_tready_i = 1'b1;
    for (int p = 0; p < NUM_S; p++) begin
      src_idx[p] = 0;
      src_len[p] = 0;
      src_pkt[p] = 1;
    end

    // Reset state: all outputs zero even with every slave valid.
    #12;
    check("rst_tvalid", 512'(bus.axi_m0_tvalid_o), 512'd0);
    check("rst_tdata",  512'(bus.axi_m0_tdata_o),  512'd0);
    check("rst_tuser",  512'(bus.axi_m0_tuser_o),  512'd0);
    check("rst_tkeep",  512'(bus.axi_m0_tkeep_o),  512'd0);
    check("rst_tlast",  512'(bus.axi_m0_tlast_o),  512'd0);
    check("rst_tready", 512'(bus.axi_s_tready_o),  512'd0);
`ifdef AXI4_SWITCH_SRC_ID_EN
    check("rst_tid",    512'(bus.axi_m0_tid_o),    512'd0);
`endif
    for (int p = 0; p < NUM_S; p++) drive_port(p);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // All four ports with 2-beat packets: 0,1,2,3 whole packets, 8 beats in 8 cycles.
    for (int p = 0; p < NUM_S; p++) load(p, 2, 2);
    cycle(1'b1);
    check("all_first_grant", 512'(seen_tready), 512'(4'b0001));
    for (int c = 0; c < 8; c++) cycle(1'b1);
    exp_q = '{exp_beat(0, 0, 1'b0), exp_beat(0, 1, 1'b1), exp_beat(1, 0, 1'b0), exp_beat(1, 1, 1'b1),
              exp_beat(2, 0, 1'b0), exp_beat(2, 1, 1'b1), exp_beat(3, 0, 1'b0), exp_beat(3, 1, 1'b1)};
    compare_obs("all_ports");
    check("all_drained_tvalid", 512'(bus.axi_m0_tvalid_o), 512'd0);

    // Single-beat packet on port 2, visible one cycle after the handshake.
    load(2, 1, 1);
    cycle(1'b1);
    check("p2_grant",  512'(seen_tready), 512'(4'b0100));
    check("p2_tvalid", 512'(bus.axi_m0_tvalid_o), 512'd1);
    check("p2_tdata",  512'(bus.axi_m0_tdata_o),  512'h0000_0000_D002_0000);
    check("p2_tuser",  512'(bus.axi_m0_tuser_o),  512'h2FFD_FFFF);
    check("p2_tkeep",  512'(bus.axi_m0_tkeep_o),  512'h0001);
    check("p2_tlast",  512'(bus.axi_m0_tlast_o),  512'd1);
    cycle(1'b1);
    check("p2_clear_tvalid", 512'(bus.axi_m0_tvalid_o), 512'd0);
    exp_q = '{exp_beat(2, 0, 1'b1)};
    compare_obs("p2_single");

    // rr_ptr is now 2: ports 0 and 3 together -> port 3 first.
    load(0, 1, 1);
    load(3, 1, 1);
    cycle(1'b1);
    check("rr_first",  512'(seen_tready), 512'(4'b1000));
    cycle(1'b1);
    check("rr_second", 512'(seen_tready), 512'(4'b0001));
    cycle(1'b1);
    exp_q = '{exp_beat(3, 0, 1'b1), exp_beat(0, 0, 1'b1)};
    compare_obs("rr_order");

    // Suppress raised on port 1 mid-packet: packet completes, then port 1 is held off.
    load(1, 6, 3);
    load(2, 1, 1);
    cycle(1'b1);
    check("sup_b0_grant", 512'(seen_tready), 512'(4'b0010));
    bus.s_req_supress = 4'b0010;
    cycle(1'b1);
    check("sup_locked_grant", 512'(seen_tready), 512'(4'b0010));
    cycle(1'b1);
    cycle(1'b1);
    check("sup_other_grant", 512'(seen_tready), 512'(4'b0100));
    cycle(1'b1);
    check("sup_blocked_a", 512'(seen_tready), 512'(4'b0000));
    cycle(1'b1);
    check("sup_blocked_b", 512'(seen_tready), 512'(4'b0000));
    exp_q = '{exp_beat(1, 0, 1'b0), exp_beat(1, 1, 1'b0), exp_beat(1, 2, 1'b1), exp_beat(2, 0, 1'b1)};
    compare_obs("sup_first");
    bus.s_req_supress = 4'b0000;
    cycle(1'b1);
    check("sup_release_grant", 512'(seen_tready), 512'(4'b0010));
    cycle(1'b1);
    cycle(1'b1);
    cycle(1'b1);
    exp_q = '{exp_beat(1, 3, 1'b0), exp_beat(1, 4, 1'b0), exp_beat(1, 5, 1'b1)};
    compare_obs("sup_second");

    // Backpressure: tready_i 1,0,0,1,1,1,1 on a 4-beat packet from port 0.
    load(0, 4, 4);
    cycle(1'b1); check("bp_c1", 512'(seen_tready), 512'(4'b0001));
    cycle(1'b0); check("bp_c2", 512'(seen_tready), 512'(4'b0000));
    cycle(1'b0); check("bp_c3", 512'(seen_tready), 512'(4'b0000));
    cycle(1'b1); check("bp_c4", 512'(seen_tready), 512'(4'b0001));
    cycle(1'b1); check("bp_c5", 512'(seen_tready), 512'(4'b0001));
    cycle(1'b1); check("bp_c6", 512'(seen_tready), 512'(4'b0001));
    cycle(1'b1); check("bp_c7", 512'(seen_tready), 512'(4'b0000));
    exp_q = '{exp_beat(0, 0, 1'b0), exp_beat(0, 1, 1'b0), exp_beat(0, 2, 1'b0), exp_beat(0, 3, 1'b1)};
    compare_obs("bp_stream");

    // Reset mid-packet on port 3: outputs clear immediately, port 0 wins afterwards.
    load(3, 4, 4);
    cycle(1'b1);
    check("mid_grant", 512'(seen_tready), 512'(4'b1000));
    cycle(1'b1);
    load(0, 1, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_tvalid", 512'(bus.axi_m0_tvalid_o), 512'd0);
    check("mid_rst_tdata",  512'(bus.axi_m0_tdata_o),  512'd0);
    check("mid_rst_tlast",  512'(bus.axi_m0_tlast_o),  512'd0);
    check("mid_rst_tready", 512'(bus.axi_s_tready_o),  512'd0);
    @(posedge clk);
    #1;
    check("mid_rst_hold_tvalid", 512'(bus.axi_m0_tvalid_o), 512'd0);
    rst = 1'b0;
    obs_q.delete();
    cycle(1'b1);
    check("post_rst_grant", 512'(seen_tready), 512'(4'b0001));
    cycle(1'b1);
    check("post_rst_p3", 512'(seen_tready), 512'(4'b1000));
    cycle(1'b1);
    cycle(1'b1);
    exp_q = '{exp_beat(0, 0, 1'b1), exp_beat(3, 2, 1'b0), exp_beat(3, 3, 1'b1)};
    compare_obs("post_rst");

    // 3-beat packet from port 3 (source id 3 on every beat when enabled).
    load(3, 3, 3);
    for (int c = 0; c < 4; c++) cycle(1'b1);
    exp_q = '{exp_beat(3, 0, 1'b0), exp_beat(3, 1, 1'b0), exp_beat(3, 2, 1'b1)};
    compare_obs("p3_tid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi4_switch_nx1.md
Name: axi4_switch_nx1

Overview:
- Parametrised N-to-1 AXI4-Stream packet switch; successor to the 2-port custom switch.
- Merges NUM_S slave streams onto one master stream with packet-atomic round-robin arbitration and a per-port request-suppress mask.
- A registered output stage sustains one beat per cycle.
- Sits in front of the downstream packet consumer, replacing fixed 2-input switch instances.

Parameters:
- NUM_S, 4, number of slave ports (legal range 2..16).
- TDATA_L, 512, tdata width in bits.
- TUSER_L, 81, tuser width in bits.
- TKEEP_L, 16, tkeep width in bits.
- SEL_W, $clog2(NUM_S), derived port-index width; not to be overridden.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- s_req_supress  in  NUM_S  bit i masks port i from winning arbitration.
- axi_s_tdata_i  in  NUM_S*TDATA_L  slave tdata, port i at [i*TDATA_L +: TDATA_L].
- axi_s_tuser_i  in  NUM_S*TUSER_L  slave tuser, same packing.
- axi_s_tkeep_i  in  NUM_S*TKEEP_L  slave tkeep, same packing.
- axi_s_tlast_i  in  NUM_S  slave tlast, bit per port.
- axi_s_tvalid_i  in  NUM_S  slave tvalid, bit per port.
- axi_s_tready_o  out  NUM_S  slave tready, bit per port.
- axi_m0_tdata_o  out  TDATA_L  master tdata.
- axi_m0_tuser_o  out  TUSER_L  master tuser.
- axi_m0_tkeep_o  out  TKEEP_L  master tkeep.
- axi_m0_tlast_o  out  1  master tlast.
- axi_m0_tvalid_o  out  1  master tvalid.
- axi_m0_tready_i  in  1  master tready.

Behaviour:
- Reset (rst high, async):
  - All outputs 0, including axi_s_tready_o = 0 and the output register contents.
  - FSM returns to IDLE.
  - rr_ptr = NUM_S-1, so port 0 has first priority.
  - Reset mid-packet discards the in-flight beat and lock; no recovery beat is emitted.
- Output stage:
  - out_ok = !axi_m0_tvalid_o | axi_m0_tready_i.
  - A beat accepted from slave port g is registered into the axi_m0_* registers on the same edge.
  - Latency: 1 cycle from slave handshake to axi_m0_tvalid_o.
  - When the master handshakes with no new beat loaded, axi_m0_tvalid_o clears.
  - tdata/tuser/tkeep/tlast pass through unmodified.
- FSM state IDLE:
  - Eligible ports = axi_s_tvalid_i & ~s_req_supress.
  - Winner g = first eligible port searching rr_ptr+1, rr_ptr+2, ... modulo NUM_S.
  - axi_s_tready_o = onehot(g) & out_ok; 0 if there are no eligible ports.
  - On a beat accepted with tlast = 0: go to LOCKED with lock_idx = g.
  - On a beat accepted with tlast = 1 (single-beat packet): stay IDLE, rr_ptr <= g.
- FSM state LOCKED:
  - axi_s_tready_o = onehot(lock_idx) & out_ok; all other ports see tready 0.
  - s_req_supress is ignored; a packet in progress is never aborted or interleaved.
  - On an accepted beat with tlast = 1: go to IDLE, rr_ptr <= lock_idx.
- Boundary conditions:
  - A locked port that drops tvalid leaves a bubble; the lock is held indefinitely.
  - A suppressed port with tvalid high receives tready 0 and is never granted while in IDLE.
  - Simultaneous requests from all ports are served in rotating order, one whole packet each.
  - Back-to-back packets from one port with no other requester: full throughput, no idle cycle between packets.
  - Master backpressure stalls slave tready combinationally through out_ok; no beat is lost or duplicated.
  - Slave tready depends combinationally on axi_s_tvalid_i, s_req_supress and axi_m0_tready_i; there is no combinational path from slave tdata to any output.

Optional Feature:
- Macro: AXI4_SWITCH_SRC_ID_EN.
- Defined:
  - Adds output axi_m0_tid_o [SEL_W-1:0], reset 0, registered alongside tdata.
  - Carries the index of the slave port that sourced the beat.
- Undefined:
  - The port does not exist and no tid logic is generated.
  - All other behaviour is identical.

Test Plan:
- NUM_S=4, tready_i=1; port 2 sends 1 beat {A0010000,0} with tlast=1 -> m0 shows the same data/tlast 1 cycle after the handshake; rr_ptr=2.
- Ports 0..3 all valid with 2-beat packets at the same cycle -> output order is port0 b0, b1, port1 b0, b1, port2, port3; never interleaved; 8 beats in 8 consecutive cycles.
- Port 1 is mid 3-beat packet; s_req_supress[1] is raised after beat 0 -> beats 1 and 2 still forwarded; once back in IDLE, port 1 is not granted while the bit is set.
- Port 0 streams 4-beat packet; master tready_i toggles 1,0,0,1,... -> no loss or duplication; tlast appears only on beat 3; axi_s_tready_o[0] = 0 exactly in stall cycles where m0 is valid.
- rst is asserted for 1 cycle mid-packet on port 3 -> outputs go to 0 immediately (async); after release port 0 wins first if valid; bench expected queue is flushed.
- With AXI4_SWITCH_SRC_ID_EN defined, a packet from port 3 -> axi_m0_tid_o = 3 on every beat.
